speck_share_gen: RTL

//  Upstream feeder for speck_toplevel (3-share threshold SPECK-128/128). Accepts an

---
 rtl/speck_pkg.sv | 18 +
 rtl/speck_xorshift64.sv | 24 ++
 rtl/speck_share_gen.sv | 87 ++++++++
 3 files changed

// File: rtl/speck_pkg.sv
// speck_pkg: shared widths, mask timing, FSM encoding and the xorshift64 step for the share generator
package speck_pkg;
  localparam int SPECK_PT_W = 128;
  localparam int SPECK_KEY_W = 128;
  localparam int SPECK_SHARE_W = 256;
  localparam int SPECK_NSHARE = 3;
  localparam int MASK_CYCLES = 8;
  localparam logic [63:0] SPECK_SEED = 64'hACE1_2468_1357_BDF9;
  typedef enum logic [1:0] {IDLE = 2'd0, MASK = 2'd1, RUN = 2'd2} state_t;
  function automatic logic [63:0] xorshift64(input logic [63:0] v);
    logic [63:0] x;
    x = v;
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction
endpackage

// File: rtl/speck_xorshift64.sv
// speck_xorshift64: xorshift64 PRNG that never holds a zero state; rnd is the value the next step stores
module speck_xorshift64
  import speck_pkg::*;
#(
  parameter logic [63:0] SEED = SPECK_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  input  logic        load,
  input  logic [63:0] load_val,
  output logic [63:0] rnd
);
  logic [63:0] x;
  logic [63:0] st;
  assign st = xorshift64(x);
  assign rnd = |st ? st : SEED;
  // State register: reseed (zero falls back to SEED) takes priority over stepping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) x <= SEED;
    else if (load) x <= |load_val ? load_val : SEED;
    else if (step) x <= rnd;
  end
endmodule

// File: rtl/speck_share_gen.sv
// speck_share_gen: splits {pt,key} into three Boolean shares and drives the SPECK core handshake (option: SPECK_SHARE_RESEED_EN)
module speck_share_gen
  import speck_pkg::*;
#(
  parameter logic [63:0] SEED = SPECK_SEED,
  parameter int SHARE_W = SPECK_SHARE_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SPECK_PT_W-1:0]         pt,
  input  logic [SPECK_KEY_W-1:0]        key,
  output logic [SPECK_NSHARE*SHARE_W-1:0] d_out,
  output logic                          core_start,
  input  logic                          core_done,
`ifdef SPECK_SHARE_RESEED_EN
  input  logic                          seed_valid,
  input  logic [63:0]                   seed,
`endif
  output logic                          busy
);
  state_t state, nxt;
  logic [2:0] cnt;
  logic [SHARE_W-1:0] x_reg;
  logic [2*SHARE_W-1:0] r, r_nxt;
  logic [63:0] rnd;
  logic [63:0] seed_in;
  logic seed_ld;
  logic accept;
`ifdef SPECK_SHARE_RESEED_EN
  assign seed_ld = state == IDLE && seed_valid;
  assign seed_in = seed;
`else
  assign seed_ld = 1'b0;
  assign seed_in = '0;
`endif
  assign in_ready = reset_n && state == IDLE && !seed_ld;
  assign accept = in_valid && in_ready;
  assign core_start = state == RUN;
  assign busy = state != IDLE;
  speck_xorshift64 #(.SEED(SEED)) u_prng (
    .clk(clk),
    .reset_n(reset_n),
    .step(state == MASK),
    .load(seed_ld),
    .load_val(seed_in),
    .rnd(rnd)
  );
  // Mask image with this cycle's random word merged into its 64-bit slot
  always_comb begin
    r_nxt = r;
    r_nxt[{cnt, 6'd0} +: 64] = rnd;
  end
  // Next state: accept in IDLE, fixed-length MASK, wait for core_done in RUN
  always_comb begin
    nxt = state;
    if (accept) nxt = MASK;
    else if (state == MASK && cnt == 3'(MASK_CYCLES - 1)) nxt = RUN;
    else if (state == RUN && core_done) nxt = IDLE;
  end
  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  end
  // Capture input, accumulate mask words, publish shares on the last MASK cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      x_reg <= '0;
      r <= '0;
      d_out <= '0;
    end else begin
      if (accept) begin
        x_reg <= {pt, key};
        cnt <= '0;
      end
      if (state == MASK) begin
        r <= r_nxt;
        cnt <= cnt + 3'd1;
        if (cnt == 3'(MASK_CYCLES - 1))
          d_out <= {r_nxt[2*SHARE_W-1:SHARE_W], r_nxt[SHARE_W-1:0], x_reg ^ r_nxt[SHARE_W-1:0] ^ r_nxt[2*SHARE_W-1:SHARE_W]};
      end
    end
  end
endmodule
